// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gate_sweep_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Reference truth tables for two-input gates; bit i = y for stim == i
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

    // Width of the settle counter (settle range 0..15)
    localparam int SETTLE_W = 4;

    // Number of input vectors for a gate with n_in inputs
    function automatic int NV(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// Loadable down-counter with zero flag; holds each vector for the settle time.
// Latency: load/decrement visible one cycle after the edge; zero flag is combinational from the count.
// Backpressure: none; load has priority over decrement, decrement stops at zero.
module sweep_settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload wins, otherwise count down and saturate at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps every input vector of a small gate, captures its truth table and checks it against EXPECT.
// Latency: NV*(SETTLE+1) cycles from accepted start to the final sample; done pulses the cycle after.
// Backpressure: none; start is ignored while a sweep is in flight, abort cancels without a done.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int                     N_IN   = 2,
    parameter int                     SETTLE = 0,
    parameter logic [NV(N_IN)-1:0]    EXPECT = TT_AND2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 y_in,
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NV(N_IN)-1:0]  tt,
    output logic [N_IN:0]        err_cnt,
    output logic [N_IN-1:0]      first_err
);

    localparam int NVEC = NV(N_IN);

    state_e             state_q, state_d;
    logic [N_IN-1:0]    idx_q, idx_d;
    logic [N_IN-1:0]    stim_q, stim_d;
    logic [NVEC-1:0]    tt_q, tt_d;
    logic [N_IN:0]      err_cnt_q, err_cnt_d;
    logic [N_IN-1:0]    first_err_q, first_err_d;
    logic               pass_q, pass_d;

    logic               wait_zero;
    logic               timer_load;
    logic               timer_dec;
    logic               last_vec;
    logic               mismatch;
    logic [N_IN:0]      err_nxt;
    logic               accept_start;
    logic               run_go;

    assign accept_start = (state_q == IDLE) && start;
    // A sample happens on a RUN edge that is not aborted and has no settle left
    assign run_go       = (state_q == RUN) && !abort && wait_zero;
    assign last_vec     = (idx_q == {N_IN{1'b1}});
    assign mismatch     = (y_in != EXPECT[idx_q]);
    assign err_nxt      = mismatch ? (err_cnt_q + 1'b1) : err_cnt_q;

    // Reload the settle time on start and whenever a new vector is presented
    assign timer_load = accept_start || (run_go && !last_vec);
    assign timer_dec  = (state_q == RUN) && !abort && !wait_zero;

    sweep_settle_timer #(
        .W (SETTLE_W)
    ) u_settle (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .load_val_i (SETTLE_W'(SETTLE)),
        .dec_i      (timer_dec),
        .zero_o     (wait_zero)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: abort only matters in RUN, FIN always lasts one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (wait_zero && last_vec) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == FIN);
    end

    // Datapath next-state: vector index, stimulus and the result registers
    always_comb begin
        idx_d       = idx_q;
        stim_d      = stim_q;
        tt_d        = tt_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;
        unique case (state_q)
            IDLE: begin
                stim_d = '0;
                if (start) begin
                    idx_d       = '0;
                    tt_d        = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    idx_d       = '0;
                    stim_d      = '0;
                    tt_d        = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                end else if (wait_zero) begin
                    tt_d[idx_q] = y_in;
                    err_cnt_d   = err_nxt;
                    // Zero count before this sample means this is the lowest failing index
                    if (mismatch && (err_cnt_q == '0)) begin
                        first_err_d = idx_q;
                    end
                    if (last_vec) begin
                        pass_d = (err_nxt == '0);
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        stim_d = idx_q + 1'b1;
                    end
                end
            end
            FIN: begin
                stim_d = '0;
                idx_d  = '0;
            end
            default: begin
                stim_d = '0;
                idx_d  = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            stim_q      <= '0;
            tt_q        <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            stim_q      <= stim_d;
            tt_q        <= tt_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
        end
    end

    assign stim      = stim_q;
    assign tt        = tt_q;
    assign err_cnt   = err_cnt_q;
    assign first_err = first_err_q;
    assign pass      = pass_q;

endmodule
